// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte type, block size and SubBytes engine states.
package aes_pkg;
   localparam int unsigned AES_BLOCK_BYTES = 16;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;
endpackage

// File: rtl/sbox_lane.sv
// Combinational single-byte AES S-box lane, forward and (optionally) inverse.
module sbox_lane
   import aes_pkg::*;
#(
   parameter int unsigned INV_EN = 1
) (
   input  logic [7:0] value,
   input  logic       inv,
   output logic [7:0] result
);

   localparam byte_t FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   generate
      if (INV_EN != 0) begin : g_inv
         localparam byte_t INV [256] = '{
            8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
            8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
            8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
            8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
            8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
            8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
            8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
            8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
            8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
            8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
            8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
            8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
            8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
            8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
            8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
            8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
         };
         assign result = inv ? INV[value] : FWD[value];
      end else begin : g_fwd
         // Forward-only build: the mode select has nothing to steer.
         logic unused_inv;
         assign unused_inv = inv;
         assign result     = FWD[value];
      end
   endgenerate

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle SubBytes engine: substitutes LANES bytes per cycle of a DATA_BYTES block,
// with valid/ready handshakes towards the round-state register and ShiftRows.
module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int unsigned DATA_BYTES = AES_BLOCK_BYTES,
   parameter int unsigned LANES      = 4,
   parameter int unsigned INV_EN     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic                    in_inv,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*DATA_BYTES-1:0] out_data,
   output logic                    busy
);

   localparam int unsigned N  = DATA_BYTES / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   state_t                         state, state_nxt;
   logic [CW-1:0]                  cnt, cnt_nxt;
   logic [DATA_BYTES-1:0][7:0]     work, work_nxt;
   logic [DATA_BYTES-1:0][7:0]     res, res_nxt;
   logic                           mode, mode_nxt;
   logic [IW-1:0]                  base;
   byte_t                          lane_in  [LANES];
   byte_t                          lane_out [LANES];

   // First byte of the group handled this cycle.
   assign base = IW'(int'(cnt) * int'(LANES));

   generate
      for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
         assign lane_in[k] = work[base + IW'(k)];
         sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .value  (lane_in[k]),
            .inv    (mode),
            .result (lane_out[k])
         );
      end
   endgenerate

   // Next-state and datapath update.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      work_nxt  = work;
      mode_nxt  = mode;
      res_nxt   = res;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               work_nxt  = in_data;
               mode_nxt  = in_inv && (INV_EN != 0);
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < int'(LANES); k++) begin
               work_nxt[base + IW'(k)] = lane_out[k];
            end
            if (cnt == CW'(N - 1)) begin
               // Result register only ever sees a fully substituted block.
               res_nxt   = work_nxt;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               res_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         work      <= '0;
         mode      <= 1'b0;
         res       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         work      <= work_nxt;
         mode      <= mode_nxt;
         res       <= res_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
      end
   end

   assign out_data = res;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine across lane counts and with the inverse table removed.
module tb_sub_bytes_engine;

   localparam int NI = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_inv = 1'b0;
   logic         in_valid_v  [NI];
   logic         out_ready_v [NI];
   logic         in_ready_o  [NI];
   logic         out_valid_o [NI];
   logic         busy_o      [NI];
   logic [127:0] out_data_o  [NI];

   int tests = 0;
   int fails = 0;

   logic [7:0] sbox_m [256];
   logic [7:0] inv_m  [256];
   int         lat_exp [NI] = '{4, 16, 8, 1, 4};

   always #5 clk = ~clk;

   sub_bytes_engine #(.DATA_BYTES(16), .LANES(4), .INV_EN(1)) u_l4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_o[0]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_o[0]),
      .out_ready(out_ready_v[0]), .out_data(out_data_o[0]), .busy(busy_o[0]));
   sub_bytes_engine #(.DATA_BYTES(16), .LANES(1), .INV_EN(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_o[1]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_o[1]),
      .out_ready(out_ready_v[1]), .out_data(out_data_o[1]), .busy(busy_o[1]));
   sub_bytes_engine #(.DATA_BYTES(16), .LANES(2), .INV_EN(1)) u_l2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_o[2]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_o[2]),
      .out_ready(out_ready_v[2]), .out_data(out_data_o[2]), .busy(busy_o[2]));
   sub_bytes_engine #(.DATA_BYTES(16), .LANES(16), .INV_EN(1)) u_l16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_o[3]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_o[3]),
      .out_ready(out_ready_v[3]), .out_data(out_data_o[3]), .busy(busy_o[3]));
   sub_bytes_engine #(.DATA_BYTES(16), .LANES(4), .INV_EN(0)) u_fwd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_o[4]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_o[4]),
      .out_ready(out_ready_v[4]), .out_data(out_data_o[4]), .busy(busy_o[4]));

   // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : sbox_m[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push one block through engine id with out_ready held high; returns the result.
   task automatic run_block(input int id, input logic [127:0] d, input logic inv,
                            output logic [127:0] res);
      int n;
      @(negedge clk);
      in_data = d; in_inv = inv; in_valid_v[id] = 1'b1; out_ready_v[id] = 1'b1;
      n = 0;
      while (in_ready_o[id] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("accept_ready", 128'(in_ready_o[id]), 128'(1));
      @(negedge clk);
      in_valid_v[id] = 1'b0; in_data = ~d; in_inv = ~inv;
      check("busy_run", 128'(busy_o[id]), 128'(1));
      n = 0;
      while (out_valid_o[id] !== 1'b1 && n < 64) begin
         check("no_partial", out_data_o[id], 128'(0));
         @(negedge clk); n++;
      end
      check("latency", 128'(n), 128'(lat_exp[id]));
      res = out_data_o[id];
      @(negedge clk);
      check("drain_valid", 128'(out_valid_o[id]), 128'(0));
      check("drain_ready", 128'(in_ready_o[id]), 128'(1));
   endtask

   initial begin
      logic [127:0] r, d, x, held;
      logic         inv;
      int           n;
      int           order [4] = '{1, 2, 0, 3};

      for (int v = 0; v < 256; v++) begin
         sbox_m[v]         = affine(ginv(8'(v)));
         inv_m[sbox_m[v]]  = 8'(v);
      end
      for (int i = 0; i < NI; i++) begin
         in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1;
      end

      repeat (3) @(negedge clk);
      check("rst_in_ready",  128'(in_ready_o[0]), 128'(1));
      check("rst_out_valid", 128'(out_valid_o[0]), 128'(0));
      check("rst_out_data",  out_data_o[0], 128'(0));
      check("rst_busy",      128'(busy_o[0]), 128'(0));
      rst_n = 1'b1;

      run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, r);
      check("fips_fwd", r, 128'hd42711aee0bf98f1b8b45de51e415230);
      run_block(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, r);
      check("fips_inv", r, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

      d = rnd_block();
      d[7:0] = 8'h63; d[15:8] = 8'h16; d[23:16] = 8'hed;
      run_block(0, d, 1'b1, r);
      check("inv_63", 128'(r[7:0]), 128'h00);
      check("inv_16", 128'(r[15:8]), 128'hff);
      check("inv_ed", 128'(r[23:16]), 128'h53);
      check("inv_spot_blk", r, model(d, 1'b1));

      // Every byte value through each lane configuration.
      foreach (order[o]) begin
         for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * j + i);
            run_block(order[o], d, 1'b0, r);
            check("exh_fwd", r, model(d, 1'b0));
            if (j == 0) check("s_00", 128'(r[7:0]), 128'h63);
            if (j == 5) check("s_53", 128'(r[31:24]), 128'hed);
         end
      end
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * j + i);
         run_block(0, d, 1'b1, r);
         check("exh_inv", r, model(d, 1'b1));
      end

      for (int t = 0; t < 20; t++) begin
         d = rnd_block(); inv = 1'($urandom);
         run_block(t % 4, d, inv, r);
         check("rand_blk", r, model(d, inv));
      end

      // Backpressure: result held in DONE while a new block waits.
      @(negedge clk);
      d = rnd_block(); in_data = d; in_inv = 1'b0;
      in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      n = 0;
      while (out_valid_o[0] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("bp_valid", 128'(out_valid_o[0]), 128'(1));
      held = out_data_o[0];
      check("bp_data", held, model(d, 1'b0));
      x = rnd_block(); in_data = x; in_inv = 1'b1; in_valid_v[0] = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("bp_hold_valid", 128'(out_valid_o[0]), 128'(1));
         check("bp_hold_data",  out_data_o[0], held);
         check("bp_hold_ready", 128'(in_ready_o[0]), 128'(0));
      end
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      check("bp_rel_valid", 128'(out_valid_o[0]), 128'(0));
      check("bp_rel_ready", 128'(in_ready_o[0]), 128'(1));
      check("bp_rel_busy",  128'(busy_o[0]), 128'(0));
      @(negedge clk);
      check("bp_accept_busy",  128'(busy_o[0]), 128'(1));
      check("bp_accept_ready", 128'(in_ready_o[0]), 128'(0));
      in_valid_v[0] = 1'b0; in_data = ~x;
      n = 0;
      while (out_valid_o[0] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("bp_pending_valid", 128'(out_valid_o[0]), 128'(1));
      check("bp_pending_data",  out_data_o[0], model(x, 1'b1));
      @(negedge clk);

      // Asynchronous reset with cnt = 2, then a clean block.
      d = rnd_block(); in_data = d; in_inv = 1'b0; in_valid_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rr_busy_pre", 128'(busy_o[0]), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("rr_out_valid", 128'(out_valid_o[0]), 128'(0));
      check("rr_out_data",  out_data_o[0], 128'(0));
      check("rr_in_ready",  128'(in_ready_o[0]), 128'(1));
      check("rr_busy",      128'(busy_o[0]), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      d = rnd_block();
      run_block(0, d, 1'b0, r);
      check("rr_next_blk", r, model(d, 1'b0));

      // Forward-only engine ignores in_inv.
      run_block(4, 128'(0), 1'b1, r);
      check("fwdonly_zero", r, {16{8'h63}});
      for (int t = 0; t < 4; t++) begin
         d = rnd_block();
         run_block(4, d, 1'b1, r);
         check("fwdonly_rand", r, model(d, 1'b0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
